// File: rtl/layer_stream_if.sv
// layer_stream_if: input and output sample streams of one layer_stream
// x_valid/x_ready/x_in : serial input samples, one per handshake
// y_valid/y_ready/y_data/y_last : serialised neuron results, y_last on the final one
// master drives x_* and y_ready, slave (the layer) drives x_ready and y_*
interface layer_stream_if #(parameter int DW = 16);
  logic x_valid, x_ready, y_valid, y_ready, y_last;
  logic [DW-1:0] x_in, y_data;
  modport master(output x_valid, x_in, y_ready, input x_ready, y_valid, y_data, y_last);
  modport slave(input x_valid, x_in, y_ready, output x_ready, y_valid, y_data, y_last);
endinterface

// File: rtl/layer_stream.sv
// layer_stream: fully connected layer fed from a sample stream, results re-serialised onto an output stream
// clk, rst                        : clock, synchronous active-high reset
// weight_valid/value, bias_valid/value, config_layer_num/neuron_num : runtime weight and bias load
// s (layer_stream_if.slave)       : input stream x_*, output stream y_*
// busy                            : vector partially accepted or output buffer full
// err                             : sticky flag, neuron outputs arrived out of step
// class_valid, class_idx          : argmax of each drained vector, present only with LAYER_ARGMAX_EN
module layer_stream #(
  parameter int NN = 10,
  parameter int numWeight = 784,
  parameter int dataWidth = 16,
  parameter int layerNum = 1,
  parameter int sigmoidSize = 10,
  parameter int weightIntWidth = 4,
  parameter string actType = "relu"
) (
  input  logic clk,
  input  logic rst,
  input  logic weight_valid,
  input  logic bias_valid,
  input  logic [31:0] weight_value,
  input  logic [31:0] bias_value,
  input  logic [31:0] config_layer_num,
  input  logic [31:0] config_neuron_num,
  layer_stream_if.slave s,
  output logic busy,
  output logic err,
  output logic class_valid,
  output logic [$clog2(NN)-1:0] class_idx
);
  localparam int IW = $clog2(numWeight + 1);
  localparam int AW = numWeight > 1 ? $clog2(numWeight) : 1;
  localparam int CW = $clog2(NN);
  localparam int FW = dataWidth - weightIntWidth;
  localparam int PW = 2 * dataWidth;
  localparam bit SIG = actType == "sigmoid";
  localparam logic [dataWidth-1:0] SM = ~dataWidth'((1 << (dataWidth - sigmoidSize)) - 1);
  typedef enum logic {EMPTY, DRAIN} st_t;
  st_t st, st_n;
  logic [IW-1:0] icnt;
  logic [CW-1:0] okcnt;
  logic [NN-1:0] ov;
  logic [dataWidth-1:0] nout [NN];
  logic [dataWidth-1:0] obuf [NN];
  logic rstn, last_x, acc_x, cap, hs, last_hs, unused;
  assign unused = ^{weight_value[31:dataWidth], bias_value[31:dataWidth]};
  assign rstn = ~rst;
  assign last_x = icnt == IW'(numWeight - 1);
  assign hs = s.y_valid && s.y_ready;
  assign last_hs = hs && s.y_last;
  // the last beat waits until the buffer is free, so a capture can never land in DRAIN
  assign s.x_ready = !rst && (!last_x || st == EMPTY || last_hs);
  assign acc_x = s.x_valid && s.x_ready;
  assign cap = &ov;
  assign busy = icnt != '0 || st == DRAIN;
  always_ff @(posedge clk)
    if (rst) icnt <= '0;
    else if (acc_x) icnt <= last_x ? '0 : icnt + IW'(1);
  // saturating activation; sigmoid is a hard-sigmoid 0.25x+0.5 quantised to sigmoidSize bits
  function automatic logic [dataWidth-1:0] act(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] t, hi;
    t = SIG ? (v >>> 2) + (PW'(1) <<< (FW - 1)) : v;
    hi = SIG ? PW'(1) <<< FW : PW'((1 <<< (dataWidth - 1)) - 1);
    t = t[PW-1] ? '0 : (t > hi ? hi : t);
    return SIG ? dataWidth'(t) & SM : dataWidth'(t);
  endfunction
  for (genvar i = 0; i < NN; i++) begin : g_n
    logic signed [dataWidth-1:0] w [numWeight];
    logic signed [dataWidth-1:0] b;
    logic [AW-1:0] wp;
    logic signed [PW-1:0] acc, prod, sum;
    logic [dataWidth-1:0] o;
    logic v, sel;
    assign sel = config_layer_num == 32'(layerNum) && config_neuron_num == 32'(i);
    assign prod = PW'($signed(s.x_in)) * PW'(w[icnt[AW-1:0]]);
    assign sum = acc + (prod >>> FW) + PW'(b);
    assign ov[i] = v;
    assign nout[i] = o;
    always_ff @(posedge clk) begin
      if (weight_valid && sel) w[wp] <= weight_value[dataWidth-1:0];
      if (bias_valid && sel) b <= bias_value[dataWidth-1:0];
    end
    always_ff @(posedge clk)
      if (!rstn) begin
        wp <= '0;
        acc <= '0;
        v <= 1'b0;
        o <= '0;
      end else begin
        if (weight_valid && sel) wp <= wp == AW'(numWeight - 1) ? '0 : wp + AW'(1);
        v <= acc_x && last_x;
        if (acc_x) acc <= last_x ? '0 : acc + (prod >>> FW);
        if (acc_x && last_x) o <= act(sum);
      end
  end
  always_ff @(posedge clk) st <= rst ? EMPTY : st_n;
  always_comb st_n = st == EMPTY ? (cap ? DRAIN : EMPTY) : (last_hs ? EMPTY : DRAIN);
  always_comb begin
    s.y_valid = st == DRAIN;
    s.y_data = st == DRAIN ? obuf[okcnt] : '0;
    s.y_last = st == DRAIN && okcnt == CW'(NN - 1);
  end
  always_ff @(posedge clk)
    if (rst) begin
      okcnt <= '0;
      err <= 1'b0;
    end else begin
      if (cap) okcnt <= '0;
      else if (hs) okcnt <= s.y_last ? '0 : okcnt + CW'(1);
      if (|ov && !cap) err <= 1'b1;
    end
  always_ff @(posedge clk) if (cap) obuf <= nout;
`ifdef LAYER_ARGMAX_EN
  logic signed [dataWidth-1:0] mx;
  logic [CW-1:0] mi, ni;
  logic gt;
  // strict greater-than keeps the lower index on ties
  assign gt = okcnt == '0 || $signed(s.y_data) > mx;
  assign ni = gt ? okcnt : mi;
  always_ff @(posedge clk)
    if (rst) begin
      mx <= '0;
      mi <= '0;
      class_valid <= 1'b0;
      class_idx <= '0;
    end else begin
      class_valid <= last_hs;
      if (hs) begin
        mx <= gt ? $signed(s.y_data) : mx;
        mi <= ni;
      end
      if (last_hs) class_idx <= ni;
    end
`else
  assign class_valid = 1'b0;
  assign class_idx = '0;
`endif
endmodule

// File: tb/tb_layer_stream.sv
// tb_layer_stream: directed checks of layer_stream with NN=3, numWeight=4, relu
module tb_layer_stream;
  localparam int NN = 3, NW = 4, DW = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic weight_valid = 1'b0, bias_valid = 1'b0;
  logic [31:0] weight_value = '0, bias_value = '0, config_layer_num = '0, config_neuron_num = '0;
  logic busy, err, class_valid;
  logic [$clog2(NN)-1:0] class_idx;
  int n_tests = 0, n_fail = 0, exp_i = 0;
  logic [15:0] exp_y [NN];
  layer_stream_if #(.DW(DW)) sif();
  layer_stream #(.NN(NN), .numWeight(NW), .dataWidth(DW), .layerNum(1), .sigmoidSize(10),
    .weightIntWidth(4), .actType("relu")) dut (
    .clk(clk), .rst(rst), .weight_valid(weight_valid), .bias_valid(bias_valid),
    .weight_value(weight_value), .bias_value(bias_value), .config_layer_num(config_layer_num),
    .config_neuron_num(config_neuron_num), .s(sif), .busy(busy), .err(err),
    .class_valid(class_valid), .class_idx(class_idx));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  always @(negedge clk)
    if (!rst && dut.cap === 1'b1 && sif.y_valid === 1'b1) begin
      n_fail++;
      $error("FAIL cap_in_drain: observed capture while draining, expected none");
    end
  task automatic load(input logic [15:0] step);
    for (int n = 0; n < NN; n++) begin
      config_layer_num = 1;
      config_neuron_num = n;
      bias_value = 32'(n * step);
      bias_valid = 1'b1;
      weight_value = 32'h1000;
      weight_valid = 1'b1;
      for (int k = 0; k < NW; k++) begin
        tick;
        bias_valid = 1'b0;
      end
      weight_valid = 1'b0;
      exp_y[n] = 16'h4000 + 16'(n * step);
    end
    exp_i = 0;
    for (int n = 1; n < NN; n++) if ($signed(exp_y[n]) > $signed(exp_y[exp_i])) exp_i = n;
  endtask
  task automatic send(input int nb);
    for (int k = 0; k < nb; k++) begin
      int t;
      t = 0;
      sif.x_valid = 1'b1;
      sif.x_in = 16'h1000;
      #1;
      while (sif.x_ready !== 1'b1 && t < 40) begin
        tick;
        t++;
      end
      if (t == 40) chk("x_ready_timeout", 32'(sif.x_ready), 1);
      tick;
    end
    sif.x_valid = 1'b0;
  endtask
  task automatic wait_y;
    int t;
    t = 0;
    while (sif.y_valid !== 1'b1 && t < 40) begin
      tick;
      t++;
    end
    if (t == 40) chk("y_valid_timeout", 32'(sif.y_valid), 1);
  endtask
  task automatic drain(input logic [4:0] pat);
    int idx;
    idx = 0;
    for (int c = 0; c < 20 && idx < NN; c++) begin
      sif.y_ready = pat[c % 5];
      #1;
      chk("y_valid", 32'(sif.y_valid), 1);
      chk("y_data", 32'(sif.y_data), 32'(exp_y[idx]));
      chk("y_last", 32'(sif.y_last), 32'(idx == NN - 1));
      if (sif.y_ready) idx++;
      tick;
    end
    chk("drain_count", idx, NN);
    chk("y_valid_after", 32'(sif.y_valid), 0);
`ifdef LAYER_ARGMAX_EN
    chk("class_valid_pulse", 32'(class_valid), 1);
    chk("class_idx", 32'(class_idx), exp_i);
    tick;
    chk("class_valid_drop", 32'(class_valid), 0);
`else
    chk("class_valid_off", 32'(class_valid), 0);
    chk("class_idx_off", 32'(class_idx), 0);
`endif
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    sif.x_valid = 1'b0;
    sif.x_in = '0;
    sif.y_ready = 1'b0;
    tick;
    tick;
    chk("rst_x_ready", 32'(sif.x_ready), 0);
    chk("rst_y_valid", 32'(sif.y_valid), 0);
    chk("rst_y_data", 32'(sif.y_data), 0);
    chk("rst_y_last", 32'(sif.y_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_class_valid", 32'(class_valid), 0);
    chk("rst_class_idx", 32'(class_idx), 0);
    rst = 1'b0;
    tick;
    chk("x_ready_after_rst", 32'(sif.x_ready), 1);
    load(16'h0100);
    sif.y_ready = 1'b1;
    send(NW);
    chk("latency_not_yet", 32'(sif.y_valid), 0);
    tick;
    chk("latency_y_valid", 32'(sif.y_valid), 1);
    chk("busy_full", 32'(busy), 1);
    drain(5'b11111);
    chk("err_clean", 32'(err), 0);
    sif.y_ready = 1'b0;
    send(NW);
    wait_y;
    drain(5'b11001);
    sif.y_ready = 1'b0;
    send(NW);
    wait_y;
    send(NW - 1);
    sif.x_valid = 1'b1;
    #1;
    chk("gate_x_ready", 32'(sif.x_ready), 0);
    chk("gate_busy", 32'(busy), 1);
    tick;
    chk("gate_x_ready_hold", 32'(sif.x_ready), 0);
    chk("stall_y_data", 32'(sif.y_data), 32'(exp_y[0]));
    sif.y_ready = 1'b1;
    #1;
    chk("sim_d0", 32'(sif.y_data), 32'(exp_y[0]));
    chk("sim_xr0", 32'(sif.x_ready), 0);
    tick;
    chk("sim_d1", 32'(sif.y_data), 32'(exp_y[1]));
    chk("sim_xr1", 32'(sif.x_ready), 0);
    tick;
    chk("sim_d2", 32'(sif.y_data), 32'(exp_y[2]));
    chk("sim_last", 32'(sif.y_last), 1);
    chk("sim_xr2", 32'(sif.x_ready), 1);
    tick;
    sif.x_valid = 1'b0;
    #1;
    chk("sim_empty", 32'(sif.y_valid), 0);
    chk("sim_busy", 32'(busy), 0);
`ifdef LAYER_ARGMAX_EN
    chk("sim_class_valid", 32'(class_valid), 1);
`endif
    tick;
    chk("second_result", 32'(sif.y_valid), 1);
    drain(5'b11111);
    send(2);
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_x_ready", 32'(sif.x_ready), 0);
    tick;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_y_valid", 32'(sif.y_valid), 0);
    chk("mid_rst_y_data", 32'(sif.y_data), 0);
    chk("mid_rst_y_last", 32'(sif.y_last), 0);
    chk("mid_rst_err", 32'(err), 0);
    rst = 1'b0;
    tick;
    send(NW);
    tick;
    chk("fresh_y_valid", 32'(sif.y_valid), 1);
    drain(5'b11111);
    send(NW);
    force dut.ov = 3'b101;
    #1;
    chk("err_before", 32'(err), 0);
    tick;
    chk("err_set", 32'(err), 1);
    chk("err_no_capture", 32'(sif.y_valid), 0);
    force dut.ov = 3'b010;
    tick;
    release dut.ov;
    #1;
    chk("err_late", 32'(err), 1);
    repeat (3) tick;
    chk("err_sticky", 32'(err), 1);
    chk("err_y_valid", 32'(sif.y_valid), 0);
    rst = 1'b1;
    tick;
    chk("err_cleared", 32'(err), 0);
    rst = 1'b0;
    tick;
    load(16'h0000);
    send(NW);
    wait_y;
    drain(5'b11111);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
